// File: rtl/bnn_conv3x3_mk.sv
// bnn_conv3x3_mk: multi-kernel binary 3x3 convolution engine.
// Streams square binary images (one row per word) from the input SRAM and
// writes one thresholded XNOR/popcount output row per kernel and output row.
module bnn_conv3x3_mk #(
  parameter int MAX_DIM = 16,
  parameter int NUM_K   = 2,
  parameter int WBASE   = 1,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic              dut_error,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data
);

  localparam int K_W   = (NUM_K > 1) ? $clog2(NUM_K) : 1;
  localparam int DIM_W = $clog2(MAX_DIM + 1);
  localparam logic [DATA_W-1:0] TERM_WORD = DATA_W'(255);
  localparam logic [DATA_W-1:0] DIM_LO    = DATA_W'(3);
  localparam logic [DATA_W-1:0] DIM_HI    = DATA_W'(MAX_DIM);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_HDR, S_FILL, S_RUN, S_NEXT, S_DONE
  } state_t;

  state_t             state;
  logic [3:0]         step;
  logic [K_W-1:0]     k_idx;
  logic [DIM_W-1:0]   n_dim;
  logic [DIM_W-1:0]   row_cnt;
  logic [ADDR_W-1:0]  img_base;
  logic [ADDR_W-1:0]  wr_cnt;
  logic [DATA_W-1:0]  win0;
  logic [DATA_W-1:0]  win1;
  logic [8:0]         kern [0:NUM_K-1];
  logic [3:0]         thr  [0:NUM_K-1];

  logic [8:0]         kern_sel;
  logic [3:0]         thr_eff;
  logic [DIM_W-1:0]   last_col;
  logic [8:0]         win9;
  logic [3:0]         cnt;
  logic [DATA_W-1:0]  row_out;
  logic [ADDR_W-1:0]  next_base;
  logic               unused_wbits;

  assign unused_wbits = ^wmem_dut_read_data[DATA_W-1:13];
  assign next_base    = img_base + ADDR_W'(n_dim) + 1'b1;

  // One output row: window rows win0/win1 plus the row word arriving now.
  always_comb begin
    kern_sel = kern[k_idx];
    thr_eff  = (thr[k_idx] == 4'd0) ? 4'd5 : thr[k_idx];
    last_col = n_dim - DIM_W'(3);
    row_out  = '0;
    win9     = '0;
    cnt      = '0;
    for (int c = 0; c <= DATA_W - 3; c++) begin
      win9 = {sram_dut_read_data[c +: 3], win1[c +: 3], win0[c +: 3]};
      cnt  = '0;
      for (int b = 0; b < 9; b++) begin
        cnt = cnt + {3'b000, ~(win9[b] ^ kern_sel[b])};
      end
      // Thresholds above 9 can never be met by a 9-bit popcount.
      row_out[c] = (cnt >= thr_eff) && (c <= int'(last_col));
    end
  end

  // Sequencer: weight load, header decode, window fill, row streaming.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state                  <= S_IDLE;
      step                   <= '0;
      k_idx                  <= '0;
      n_dim                  <= '0;
      row_cnt                <= '0;
      img_base               <= '0;
      wr_cnt                 <= '0;
      win0                   <= '0;
      win1                   <= '0;
      for (int i = 0; i < NUM_K; i++) begin
        kern[i] <= '0;
        thr[i]  <= '0;
      end
      dut_busy               <= 1'b0;
      dut_error              <= 1'b0;
      dut_sram_read_address  <= '0;
      dut_sram_write_address <= '0;
      dut_sram_write_data    <= '0;
      dut_sram_write_enable  <= 1'b0;
      dut_wmem_read_address  <= '0;
    end else begin
      dut_sram_write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dut_run) begin
            state                 <= S_LOAD_W;
            dut_busy              <= 1'b1;
            dut_error             <= 1'b0;
            step                  <= '0;
            k_idx                 <= '0;
            img_base              <= '0;
            wr_cnt                <= '0;
            dut_sram_read_address <= '0;
            dut_wmem_read_address <= ADDR_W'(WBASE);
          end
        end
        S_LOAD_W: begin
          // Word for address WBASE+i arrives one cycle after it is presented.
          for (int i = 0; i < NUM_K; i++) begin
            if (step == 4'(i + 1)) begin
              kern[i] <= wmem_dut_read_data[8:0];
              thr[i]  <= wmem_dut_read_data[12:9];
            end
          end
          if (step < 4'(NUM_K - 1)) begin
            dut_wmem_read_address <= dut_wmem_read_address + 1'b1;
          end
          if (step == 4'(NUM_K)) begin
            state <= S_HDR;
            step  <= '0;
          end else begin
            step <= step + 1'b1;
          end
        end
        S_HDR: begin
          // Read address already points at img_base; wait one cycle for data.
          if (step == 4'd0) begin
            step <= 4'd1;
          end else begin
            step <= '0;
            if (sram_dut_read_data == TERM_WORD) begin
              state <= S_DONE;
            end else if (sram_dut_read_data < DIM_LO || sram_dut_read_data > DIM_HI) begin
              dut_error <= 1'b1;
              state     <= S_DONE;
            end else begin
              n_dim                 <= sram_dut_read_data[DIM_W-1:0];
              dut_sram_read_address <= img_base + 1'b1;
              state                 <= S_FILL;
            end
          end
        end
        S_FILL: begin
          dut_sram_read_address <= dut_sram_read_address + 1'b1;
          if (step == 4'd1) begin
            win0 <= sram_dut_read_data;
          end
          if (step == 4'd2) begin
            win1    <= sram_dut_read_data;
            row_cnt <= '0;
            step    <= '0;
            state   <= S_RUN;
          end else begin
            step <= step + 1'b1;
          end
        end
        S_RUN: begin
          dut_sram_write_enable  <= 1'b1;
          dut_sram_write_address <= wr_cnt;
          dut_sram_write_data    <= row_out;
          wr_cnt                 <= wr_cnt + 1'b1;
          win0                   <= win1;
          win1                   <= sram_dut_read_data;
          dut_sram_read_address  <= dut_sram_read_address + 1'b1;
          row_cnt                <= row_cnt + 1'b1;
          if (row_cnt == last_col) begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (k_idx == K_W'(NUM_K - 1)) begin
            k_idx                 <= '0;
            img_base              <= next_base;
            dut_sram_read_address <= next_base;
            state                 <= S_HDR;
          end else begin
            k_idx                 <= k_idx + 1'b1;
            dut_sram_read_address <= img_base + 1'b1;
            state                 <= S_FILL;
          end
        end
        S_DONE: begin
          dut_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bnn_conv3x3_mk.md
# bnn_conv3x3_mk

Parametrised binary 3x3 convolution engine: the next-generation multi-kernel, variable-size, configurable-threshold version of the team's XNOR/popcount convolution accelerator. It streams a sequence of square binary images from the input SRAM, one row per 16-bit word. Each image is convolved with NUM_K binary 3x3 kernels, each with its own popcount threshold. Valid output rows are packed LSB-aligned into the output region of the same SRAM. It sits between the top-level run/busy control and the input/output SRAM and weight SRAM ports.

## Interface
- MAX_DIM, 16: largest supported image side N; legal N range is 3..MAX_DIM, and MAX_DIM must not exceed DATA_W.
- NUM_K, 2: number of kernels, from 1 to 8.
- WBASE, 1: weight SRAM address of kernel 0.
- ADDR_W, 12: SRAM address width.
- DATA_W, 16: SRAM data width.
- clk  in  1  clock, rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- dut_run  in  1  start pulse; sampled only in IDLE.
- dut_busy  out  1  high from the cycle after run is accepted until the job ends.
- dut_error  out  1  sticky; set on an illegal dimension word, cleared on the next accepted run.
- dut_sram_read_address  out  ADDR_W  input word address.
- sram_dut_read_data  in  DATA_W  word at the address presented the previous cycle (1-cycle latency).
- dut_sram_write_address  out  ADDR_W  output word address.
- dut_sram_write_data  out  DATA_W  output word.
- dut_sram_write_enable  out  1  write strobe, one word per cycle.
- dut_wmem_read_address  out  ADDR_W  weight word address.
- wmem_dut_read_data  in  DATA_W  weight word, 1-cycle latency.

## Operation
- **Input layout:** input words start at address 0. Each image is one dimension word N followed by N row words. In a row word, bit c is column c and bits above N-1 are ignored. A dimension word of 0x00FF terminates the job; the next image's dimension word immediately follows the previous image's last row.
- **Weight word k** (at WBASE+k):
  - bits[8:0] are the kernel. w[2:0] applies to the top row (r), w[5:3] to row r+1, and w[8:6] to row r+2. Within each triple, bit 0 is column c and bit 2 is column c+2.
  - bits[12:9] are the threshold T. T=0 means T=5, and T>9 means the output bit is never set.
- **Output bit:** out[r][c] = (popcount(XNOR(kernel, window(r..r+2, c..c+2))) >= T), for c = 0..N-3. Bits N-2 and above are written as 0.
- **Output order:** image, then kernel k = 0..NUM_K-1, then row r = 0..N-3. Addresses are contiguous from 0 across the whole job and are never reset between passes.
- **States:**
  - IDLE
  - LOAD_W: reads NUM_K weight words into registers.
  - HDR: reads the dimension word.
  - FILL: primes the three-row window for the pass.
  - RUN: streams the remaining rows and writes N-2 words.
  - NEXT: if k < NUM_K-1, increments k and re-reads the same image from its first row; otherwise advances the image base by N+1 and returns to HDR.
  - DONE
- **Illegal dimension:** a dimension word outside 3..MAX_DIM that is not 0x00FF sets dut_error and goes to DONE with no writes for that image. Earlier images' outputs stand.
- **Terminator:** the 0x00FF terminator goes to DONE.
- **DONE:** clears busy and returns to IDLE.
- **Run while busy:** dut_run asserted while busy is ignored.

## Timing
- **Reset values:** every output is 0 and the state is IDLE. Reset asserted mid-job aborts immediately; there are no pending writes after reset is released.
- **Run to first read:** run accepted at edge t → dut_busy=1 at t+1, and weight reads issue from t+1.
- **Weights:** weights are used only after all NUM_K words are captured.
- **Write burst:** within RUN, the N-2 writes of a pass are on consecutive cycles. write_enable is never high outside RUN.
- **Write data:** write_data and write_address change only in cycles where write_enable is 1 and are held otherwise.
- **End of job:** dut_busy falls 1 cycle after the terminator or illegal dimension word is captured, and no earlier than 1 cycle after the final write. dut_error is valid when busy falls.
- **Address widths:** read and write addresses are full ADDR_W counters. Wrap at 2^ADDR_W is not supported; the job must fit.

## Test plan
- **Single image, two kernels, default threshold:** NUM_K=2, one 10x10 image, weights 0x01FF and 0x0000 (T=5), then 0x00FF → 16 writes at 0..15. Kernel 0 outputs popcount(window)>=5 and kernel 1 outputs popcount(~window)>=5. Bits 8..15 are zero. Busy falls after write 15 and error=0.
- **Threshold extremes:** all-ones 12x12 image, weights 0x13FF (T=9) and 0x1200 (T=9) → addresses 0..9 = 0x03FF and addresses 10..19 = 0x0000. T=15 forces all-zero output.
- **Multi-image chaining:** images 16x16, 12x12, 3x3, then terminator, NUM_K=2 → 28+20+2 = 50 contiguous writes at 0..49. Each pass matches the golden model.
- **Illegal dimension:** first dimension word = 2 → no writes, dut_error=1, busy low. A following run with a legal image clears error and writes from address 0.
- **Immediate terminator:** dimension word 0x00FF at address 0 → zero writes, busy high for LOAD_W + HDR only, error=0.
- **Reset mid-run:** reset_b low during the RUN of a 16x16 job → all outputs 0 within the same cycle (asynchronous). A subsequent run reproduces the full expected output from address 0.
